ex_mul_unit: RTL and testbench
==============================

// Module: ex_mul_unit
// PURPOSE
//  Iterative shift-add multiplier in EX; consumes the ID/EX register outputs (read side of that bundle).
//  Detects MUL (R-type, funct7=0000001, funct3=000) and freezes PC, IF/ID and ID/EX until the product is ready.
//  Returns the low 32 product bits and the destination register for the EX/MEM write.
//  All other instructions pass untouched: no stall, result_valid_o low.
// PARAMETERS
//  BITS_PER_CYCLE  1   multiplier bits retired per BUSY cycle; legal 1,2,4,8
//  ITER            32/BITS_PER_CYCLE  derived localparam; BUSY cycle count
// PORTS
//  clk_i            in   1   clock, all state changes on rising edge
//  rst_i            in   1   synchronous active-high reset
//  ALUOp_i          in   2   ALUOp from ID/EX
//  instr_i          in  10   {funct7,funct3} from ID/EX
//  RDdata1_i        in  32   rs1 operand after forwarding mux (multiplicand)
//  RDdata2_i        in  32   rs2 operand after forwarding mux (multiplier)
//  RDaddr_i         in   5   destination register from ID/EX
//  hold_i           in   1   external stall (data cache miss); pipeline frozen
//  stall_o          out  1   freeze PC, IF/ID, ID/EX (OR-ed with hazard stall)
//  busy_o           out  1   unit in BUSY
//  result_valid_o   out  1   result_o is a MUL result for EX/MEM this cycle
//  result_o         out 32   low 32 bits of rs1*rs2 (identical for signed/unsigned)
//  RDaddr_o         out  5   destination latched at start
// BEHAVIOUR
//  Reset: state=IDLE; stall_o, busy_o, result_valid_o = 0; result_o = 0; RDaddr_o = 0.
//   rst_i wins over every other input, including mid-BUSY and DONE; the partial product is discarded.
//  mul_hit = (ALUOp_i==2'b10) && (instr_i==FUNCT_MUL).
//  IDLE: stall_o = mul_hit (combinational, same cycle).
//   On mul_hit: latch mcand<=RDdata1_i, mplier<=RDdata2_i, acc<=0, cnt<=0, RDaddr_o<=RDaddr_i; go BUSY.
//   hold_i in IDLE delays nothing here; the start happens, and ID/EX stays frozen anyway.
//  BUSY: stall_o=1, busy_o=1. Each cycle retire BITS_PER_CYCLE low multiplier bits:
//   acc += mcand * mplier[B-1:0] (mod 2^32); mcand <<= B; mplier >>= B; cnt++.
//   cnt==ITER-1 on this edge -> DONE. hold_i ignored in BUSY; iteration continues.
//   ID/EX inputs ignored in BUSY; operands come from internal copies only.
//  DONE: stall_o=0, result_valid_o=1, result_o=acc.
//   hold_i=1 -> stay DONE; result held stable.
//   hold_i=0 -> IDLE next edge; ID/EX advances on the same edge.
//   A following MUL is seen in IDLE the next cycle (back-to-back legal); the DONE-cycle instruction never restarts the unit.
//  Latency: stall_o high for ITER+1 cycles (IDLE detect + ITER BUSY); result 1 cycle after the last BUSY cycle.
//  Arithmetic: all 32-bit modulo 2^32; overflow silently truncated; no flags.
//  result_o = 0 whenever not in DONE, so the EX result mux sees no X.
// STRUCTURE
//  Shared package ex_pkg:
//   FUNCT_MUL = 10'b0000001_000; ALUOP_RTYPE = 2'b10; state encoding IDLE/BUSY/DONE (2 bits).
//  Sub-module mul_radix_step: combinational {acc,mcand,mplier} -> next values for one BITS_PER_CYCLE step.
//  Top: FSM, counter of width $clog2(ITER), operand registers.
// TESTING
//  B=1, 7*6 -> stall_o high 33 cycles; result_o=42, result_valid_o=1 in cycle 34; RDaddr_o=RDaddr_i.
//  0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; 0x80000000*2 -> 0x00000000 (truncation).
//  DONE with hold_i=1 for 3 cycles -> result_o stable, stall_o=0 all 3 cycles; IDLE after hold_i drops.
//  rst_i in BUSY cycle 10 -> next cycle IDLE: stall_o=0, busy_o=0, result_o=0; no result_valid_o pulse.
//  Back-to-back MUL (3*5 then 4*4) -> two DONE pulses carrying 15 and 16, separated by a full stall window.
//  ADD (instr_i=0) and SUB (0100000_000) -> stall_o never asserts; B=4 MUL -> stall_o high exactly 9 cycles.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants and state type for the EX-stage iterative multiplier.
package ex_pkg;

    localparam logic [9:0] FUNCT_MUL   = 10'b0000001_000;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic logic is_mul(input logic [1:0] aluop, input logic [9:0] instr);
        return (aluop == ALUOP_RTYPE) && (instr == FUNCT_MUL);
    endfunction

endpackage

// File: rtl/ex_mul_unit_if.sv
// ID/EX read-side bundle into the multiplier and its results toward EX/MEM and hazard logic.
interface ex_mul_unit_if;

    logic [1:0]  ALUOp_i;
    logic [9:0]  instr_i;
    logic [31:0] RDdata1_i;
    logic [31:0] RDdata2_i;
    logic [4:0]  RDaddr_i;
    logic        hold_i;
    logic        stall_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic [4:0]  RDaddr_o;

    modport master (
        output ALUOp_i, instr_i, RDdata1_i, RDdata2_i, RDaddr_i, hold_i,
        input  stall_o, busy_o, result_valid_o, result_o, RDaddr_o
    );

    modport slave (
        input  ALUOp_i, instr_i, RDdata1_i, RDdata2_i, RDaddr_i, hold_i,
        output stall_o, busy_o, result_valid_o, result_o, RDaddr_o
    );

endinterface

// File: rtl/mul_radix_step.sv
// One shift-add step: retires BITS_PER_CYCLE multiplier bits into the 32-bit accumulator.
module mul_radix_step #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [31:0] acc,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic [31:0] acc_next,
    output logic [31:0] mcand_next,
    output logic [31:0] mplier_next
);

    logic [31:0] partial;

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
        acc_next    = acc + partial;
        mcand_next  = mcand << BITS_PER_CYCLE;
        mplier_next = mplier >> BITS_PER_CYCLE;
    end

endmodule

// File: rtl/ex_mul_unit.sv
// Iterative MUL unit in EX: freezes the front of the pipe while it shifts and adds,
// then presents the low 32 product bits for one (or more, under hold) DONE cycles.
module ex_mul_unit
    import ex_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ex_mul_unit_if.slave  bus
);

    localparam int ITER  = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    mul_state_e       state;
    logic [31:0]      mcand;
    logic [31:0]      mplier;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd_q;

    logic [31:0] acc_next;
    logic [31:0] mcand_next;
    logic [31:0] mplier_next;
    logic        mul_hit;

    assign mul_hit = is_mul(bus.ALUOp_i, bus.instr_i);

    mul_radix_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            rd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // hold_i does not gate the start; ID/EX is frozen by our own stall anyway.
                    if (mul_hit) begin
                        mcand  <= bus.RDdata1_i;
                        mplier <= bus.RDdata2_i;
                        acc    <= '0;
                        cnt    <= '0;
                        rd_q   <= bus.RDaddr_i;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.hold_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // stall is combinational in IDLE so the MUL is frozen in ID/EX on its very first cycle.
    assign bus.stall_o        = (state == BUSY) || ((state == IDLE) && mul_hit);
    assign bus.busy_o         = (state == BUSY);
    assign bus.result_valid_o = (state == DONE);
    assign bus.result_o       = (state == DONE) ? acc : '0;
    assign bus.RDaddr_o       = rd_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed bench for ex_mul_unit: a radix-1 and a radix-4 instance checked against a
// cycle-level behavioural model every cycle, plus literal expectations per scenario.
module tb_ex_mul_unit;

    typedef struct packed {
        logic [1:0]  alu;
        logic [9:0]  instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        hold;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        busy;
        logic        valid;
        logic [31:0] result;
        logic [4:0]  rd;
    } out_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_mul_unit_if if1 ();
    ex_mul_unit_if if4 ();

    ex_mul_unit #(.BITS_PER_CYCLE(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    ex_mul_unit #(.BITS_PER_CYCLE(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(if4));

    in_t  in_v  [2];
    out_t out_v [2];

    assign in_v[0]  = {if1.ALUOp_i, if1.instr_i, if1.RDdata1_i, if1.RDdata2_i, if1.RDaddr_i, if1.hold_i};
    assign in_v[1]  = {if4.ALUOp_i, if4.instr_i, if4.RDdata1_i, if4.RDdata2_i, if4.RDaddr_i, if4.hold_i};
    assign out_v[0] = {if1.stall_o, if1.busy_o, if1.result_valid_o, if1.result_o, if1.RDaddr_o};
    assign out_v[1] = {if4.stall_o, if4.busy_o, if4.result_valid_o, if4.result_o, if4.RDaddr_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input int k, input in_t v);
        if (k == 0) begin
            if1.ALUOp_i = v.alu; if1.instr_i = v.instr; if1.RDdata1_i = v.a;
            if1.RDdata2_i = v.b; if1.RDaddr_i = v.rd; if1.hold_i = v.hold;
        end else begin
            if4.ALUOp_i = v.alu; if4.instr_i = v.instr; if4.RDdata1_i = v.a;
            if4.RDdata2_i = v.b; if4.RDaddr_i = v.rd; if4.hold_i = v.hold;
        end
    endtask

    function automatic in_t mul_in(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, input logic hold);
        return '{alu: 2'b10, instr: 10'b0000001000, a: a, b: b, rd: rd, hold: hold};
    endfunction

    function automatic in_t op_in(input logic [1:0] alu, input logic [9:0] instr);
        return '{alu: alu, instr: instr, a: 32'h1111_2222, b: 32'h3333_4444, rd: 5'd30, hold: 1'b0};
    endfunction

    // ---------------- behavioural model ----------------
    // Each MUL is a job: stall for its detect cycle plus ITER cycles, then show a*b mod 2^32.
    int          m_mode [2];   // 0 idle, 1 computing, 2 presenting
    int          m_left [2];
    logic [31:0] m_prod [2];
    logic [4:0]  m_rd   [2];
    bit          m_ok;

    function automatic int iter_of(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic bit hit(input in_t v);
        return (v.alu == 2'b10) && (v.instr == 10'b0000001000);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] <= 0;
                m_prod[k] <= '0;
                m_rd[k]   <= '0;
            end else if (m_mode[k] == 0) begin
                if (hit(in_v[k])) begin
                    m_mode[k] <= 1;
                    m_left[k] <= iter_of(k);
                    m_prod[k] <= 32'(64'(in_v[k].a) * 64'(in_v[k].b));
                    m_rd[k]   <= in_v[k].rd;
                end
            end else if (m_mode[k] == 1) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) m_mode[k] <= 2;
            end else if (!in_v[k].hold) begin
                m_mode[k] <= 0;
            end
        end
        if (rst) m_ok <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d_stall", k), 64'(out_v[k].stall),
                      64'((m_mode[k] == 1) || (m_mode[k] == 0 && hit(in_v[k]))));
                check($sformatf("u%0d_busy", k), 64'(out_v[k].busy), 64'(m_mode[k] == 1));
                check($sformatf("u%0d_valid", k), 64'(out_v[k].valid), 64'(m_mode[k] == 2));
                check($sformatf("u%0d_result", k), 64'(out_v[k].result),
                      (m_mode[k] == 2) ? 64'(m_prod[k]) : 64'd0);
                check($sformatf("u%0d_rdaddr", k), 64'(out_v[k].rd), 64'(m_rd[k]));
            end
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic run_mul(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int hold_cycles, input bit preloaded,
                           input bit chain, input logic [31:0] na, input logic [31:0] nb,
                           input logic [4:0] nrd,
                           output int stall_cnt, output int valid_at, output int valid_cnt,
                           output logic [31:0] res, output logic [4:0] res_rd);
        bit   done;
        bit   leaving;
        out_t o;
        in_t  v;
        if (!preloaded) begin
            @(posedge clk); #2;
            set_in(k, mul_in(a, b, rd, hold_cycles > 0));
        end
        stall_cnt = 0; valid_at = 0; valid_cnt = 0; res = '0; res_rd = '0;
        done = 1'b0;
        for (int c = 1; c <= 200 && !done; c++) begin
            leaving = 1'b0;
            @(negedge clk);
            o = out_v[k];
            if (o.stall) stall_cnt++;
            if (o.valid) begin
                valid_cnt++;
                if (valid_at == 0) begin
                    valid_at = c;
                    res      = o.result;
                    res_rd   = o.rd;
                end else begin
                    check("held_result", 64'(o.result), 64'(res));
                end
                leaving = !in_v[k].hold;
            end
            @(posedge clk); #2;
            if (leaving) begin
                set_in(k, chain ? mul_in(na, nb, nrd, 1'b0) : op_in(2'b10, 10'd0));
                done = 1'b1;
            end else if (valid_cnt >= hold_cycles) begin
                v = in_v[k];
                v.hold = 1'b0;
                set_in(k, v);
            end
        end
        if (!done) check("mul_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int          sc, va, vc, nop_stalls, valids;
        logic [31:0] r;
        logic [4:0]  rr;

        checks = 0; failures = 0; m_ok = 1'b0;
        rst = 1'b1;
        set_in(0, op_in(2'b10, 10'd0));
        set_in(1, op_in(2'b10, 10'd0));
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_stall",  64'(out_v[k].stall),  64'd0);
            check("rst_busy",   64'(out_v[k].busy),   64'd0);
            check("rst_valid",  64'(out_v[k].valid),  64'd0);
            check("rst_result", 64'(out_v[k].result), 64'd0);
            check("rst_rdaddr", 64'(out_v[k].rd),     64'd0);
        end
        @(posedge clk); #2;
        rst = 1'b0;

        // 7*6 on radix-1: 33 stall cycles, result in cycle 34
        run_mul(0, 32'd7, 32'd6, 5'd9, 0, 0, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("b1_7x6_stall", 64'(sc), 64'd33);
        check("b1_7x6_at",    64'(va), 64'd34);
        check("b1_7x6_cnt",   64'(vc), 64'd1);
        check("b1_7x6_res",   64'(r),  64'd42);
        check("b1_7x6_rd",    64'(rr), 64'd9);

        run_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 0, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("b1_ones_res", 64'(r), 64'h1);

        run_mul(0, 32'h8000_0000, 32'd2, 5'd2, 0, 0, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("b1_trunc_res", 64'(r), 64'h0);

        run_mul(0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31, 0, 0, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("b1_mixed_at", 64'(va), 64'd34);

        // hold_i high from the start: ignored while busy, keeps DONE for 3 extra cycles
        run_mul(0, 32'd1000, 32'd1000, 5'd7, 3, 0, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("hold_stall", 64'(sc), 64'd33);
        check("hold_cnt",   64'(vc), 64'd4);
        check("hold_res",   64'(r),  64'd1000000);

        // reset in BUSY cycle 10
        @(posedge clk); #2;
        set_in(0, mul_in(32'd11, 32'd13, 5'd3, 1'b0));
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        set_in(0, op_in(2'b10, 10'd0));
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy_stall",  64'(out_v[0].stall),  64'd0);
        check("rstbusy_busy",   64'(out_v[0].busy),   64'd0);
        check("rstbusy_result", 64'(out_v[0].result), 64'd0);
        check("rstbusy_rdaddr", 64'(out_v[0].rd),     64'd0);
        valids = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_v[0].valid) valids++;
        end
        check("rstbusy_no_pulse", 64'(valids), 64'd0);

        // back-to-back 3*5 then 4*4
        run_mul(0, 32'd3, 32'd5, 5'd1, 0, 0, 1, 32'd4, 32'd4, 5'd2, sc, va, vc, r, rr);
        check("b2b_first_res", 64'(r), 64'd15);
        run_mul(0, 32'd4, 32'd4, 5'd2, 0, 1, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("b2b_second_res",   64'(r),  64'd16);
        check("b2b_second_stall", 64'(sc), 64'd33);
        check("b2b_second_at",    64'(va), 64'd34);
        check("b2b_second_rd",    64'(rr), 64'd2);

        // non-MUL instructions never stall
        nop_stalls = 0;
        for (int j = 0; j < 3; j++) begin
            case (j)
                0:       set_in(0, op_in(2'b10, 10'b0000000_000));
                1:       set_in(0, op_in(2'b10, 10'b0100000_000));
                default: set_in(0, op_in(2'b00, 10'b0000001_000));
            endcase
            repeat (3) begin
                @(negedge clk);
                if (out_v[0].stall) nop_stalls++;
                @(posedge clk); #2;
            end
        end
        check("nonmul_stalls", 64'(nop_stalls), 64'd0);
        set_in(0, op_in(2'b10, 10'd0));

        // radix-4 instance: 9 stall cycles
        run_mul(1, 32'd7, 32'd6, 5'd17, 0, 0, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("b4_7x6_stall", 64'(sc), 64'd9);
        check("b4_7x6_at",    64'(va), 64'd10);
        check("b4_7x6_res",   64'(r),  64'd42);
        check("b4_7x6_rd",    64'(rr), 64'd17);

        run_mul(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, 0, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("b4_ones_res", 64'(r), 64'h1);

        run_mul(1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5, 2, 0, 0, '0, '0, '0, sc, va, vc, r, rr);
        check("b4_hold_cnt", 64'(vc), 64'd3);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
